axi_stream_packet_gen: RTL and testbench
========================================

# axi_stream_packet_gen

Byte-wide AXI-Stream payload source that drives deterministic test frames into the Ethernet TX path, which appends the CRC-32 FCS. It is the transmit-side counterpart of the payload sink/counter at the RX end. On a `start` pulse it emits a configured number of frames of fixed length with a per-frame incrementing byte pattern, honours `tready` backpressure, inserts a programmable inter-frame gap, and reports progress and completion.

## Interface
Parameters:
- `LEN_W`, 16: width of `frame_len`.
- `CNT_W`, 16: width of `num_frames` and `frames_sent`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a run; sampled only in IDLE.
- `num_frames` in CNT_W: frames per run; captured on accepted `start`.
- `frame_len` in LEN_W: bytes per frame; captured on accepted `start`; 0 is treated as 1.
- `ifg` in 8: idle cycles between frames; captured on accepted `start`.
- `m_axis_tdata` out 8: payload byte.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: sink ready.
- `m_axis_tlast` out 1: last byte of frame.
- `busy` out 1: high from accepted `start` until run completes.
- `done` out 1: one-cycle pulse at run completion.
- `frames_sent` out CNT_W: frames completed in current/last run.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: on `start`=1, capture config, clear `frames_sent`, clear frame index and byte index; go SEND if `num_frames`!=0, else DONE.
- SEND: `m_axis_tvalid`=1. Byte k of frame f: `tdata` = (f[7:0] + k[7:0]) mod 256, where f counts from 0 within the run and k from 0 within the frame. `tlast`=1 when k = len-1 (effective len ≥1).
- Transfer occurs when `tvalid && tready`; k advances only on transfer.
- On the `tlast` transfer: `frames_sent` += 1, f += 1, k := 0. If f+1 = `num_frames` → DONE. Else if `ifg`=0 → stay SEND (back-to-back). Else → GAP.
- GAP: `tvalid`=0 for exactly `ifg` cycles, then SEND.
- DONE: `done`=1 for one cycle, `busy`=0, → IDLE.
- `start` during SEND/GAP/DONE is ignored; config inputs are ignored except at acceptance.
- AXI rules: once `tvalid` is asserted it stays high until the transfer; `tdata`/`tlast` are stable while `tvalid && !tready`. `tvalid` never depends combinationally on `tready`.
- Counters: k is LEN_W bits, f and `frames_sent` are CNT_W bits, and neither can wrap within a run. The byte-pattern sum is 8-bit modulo.

## Timing
- Reset values: `m_axis_tdata`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `busy`=0, `done`=0, `frames_sent`=0, state IDLE.
- All outputs are registered.
- `start` sampled high at edge N → `busy`=1 and first `tvalid`=1 visible after edge N (cycle N+1).
- Last-beat transfer at edge M:
  - more frames, `ifg`=0 → next frame's first beat valid in cycle M+1, no bubble.
  - `ifg`=g>0 → `tvalid` low for cycles M+1..M+g; next first beat valid in cycle M+g+1.
  - final frame → `done`=1 and `busy`=0 in cycle M+1; `frames_sent` shows its final value in cycle M+1.
- `num_frames`=0: `busy`=1 in cycle N+1, `done` pulse in cycle N+2, no beats.
- Back-to-back runs: a new `start` is accepted in the cycle after `done`.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The partial frame is abandoned; no `done` pulse.
- `tready` held low indefinitely: the block holds the current beat; no timeout.

## Test plan
- `num_frames`=1, `frame_len`=4, `ifg`=0, `tready`=1 → beats 00,01,02,03 on four consecutive cycles with `tlast` on 03; `done` pulses the next cycle; `frames_sent`=1.
- `num_frames`=3, `frame_len`=2, `ifg`=0 → data 00,01 | 01,02 | 02,03 on six consecutive cycles with no gaps, `tlast` on every second beat, `frames_sent`=3.
- `num_frames`=2, `frame_len`=3, `ifg`=5 → exactly 5 `tvalid`=0 cycles between frame 0 `tlast` and frame 1's first beat (01).
- Random `tready` (~50%), `num_frames`=4, `frame_len`=300 → `tdata`/`tlast` stable while stalled; frame 3 bytes wrap mod 256 (03..FF,00..2E); RX sink counts 4 frames with `bad_count`=0.
- `frame_len`=0 and `num_frames`=0 cases → one 1-byte frame (00, `tlast`=1); zero-frame run gives a `done` pulse two cycles after `start`, no beats. `start` while busy has no effect.
- Assert `rst_n` low mid-frame → all outputs 0 immediately; after release the block sits in IDLE until the next `start`, then restarts at byte 00.

Source files
------------

// File: rtl/axi_stream_packet_gen.sv
// Byte-wide AXI-Stream test frame source: emits num_frames frames of frame_len bytes
// with pattern (frame + byte) mod 256, honouring backpressure and a programmable gap.
module axi_stream_packet_gen #(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_frames,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       ifg,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0] len_q, len_d, k_q, k_d;
  logic [CNT_W-1:0] num_q, num_d, f_q, f_d, sent_d;
  logic [7:0]       ifg_q, ifg_d, gap_q, gap_d;
  logic [7:0]       tdata_d;
  logic             tvalid_d, tlast_d, busy_d, done_d;
  logic             accept, xfer, last_xfer, final_frame;

  assign accept      = (state_q == S_IDLE) && start;
  assign xfer        = m_axis_tvalid && m_axis_tready;
  assign last_xfer   = xfer && m_axis_tlast;
  assign final_frame = (CNT_W'(f_q + CNT_W'(1)) == num_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a zero-frame run passes through GAP so done lands one cycle later
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_frames != '0) ? S_SEND : S_GAP;
      end
      S_SEND: begin
        if (last_xfer) begin
          if (final_frame)        state_d = S_DONE;
          else if (ifg_q == 8'd0) state_d = S_SEND;
          else                    state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (f_q == num_q)        state_d = S_DONE;
        else if (gap_q <= 8'd1)  state_d = S_SEND;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for counters and registered outputs
  always_comb begin
    len_d  = len_q;
    num_d  = num_q;
    ifg_d  = ifg_q;
    k_d    = k_q;
    f_d    = f_q;
    sent_d = frames_sent;
    gap_d  = gap_q;
    if (accept) begin
      len_d  = (frame_len == '0) ? LEN_W'(1) : frame_len;
      num_d  = num_frames;
      ifg_d  = ifg;
      k_d    = '0;
      f_d    = '0;
      sent_d = '0;
    end else if (last_xfer) begin
      k_d    = '0;
      f_d    = CNT_W'(f_q + CNT_W'(1));
      sent_d = CNT_W'(frames_sent + CNT_W'(1));
    end else if (xfer) begin
      k_d    = LEN_W'(k_q + LEN_W'(1));
    end
    if (state_q == S_GAP)      gap_d = 8'(gap_q - 8'd1);
    else if (state_d == S_GAP) gap_d = ifg_d;

    tvalid_d = (state_d == S_SEND);
    tdata_d  = tvalid_d ? 8'(8'(f_d) + 8'(k_d)) : 8'd0;
    tlast_d  = tvalid_d && (k_d == LEN_W'(len_d - LEN_W'(1)));
    busy_d   = (state_d == S_SEND) || (state_d == S_GAP);
    done_d   = (state_d == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q         <= '0;
      num_q         <= '0;
      ifg_q         <= '0;
      k_q           <= '0;
      f_q           <= '0;
      gap_q         <= '0;
      frames_sent   <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      len_q         <= len_d;
      num_q         <= num_d;
      ifg_q         <= ifg_d;
      k_q           <= k_d;
      f_q           <= f_d;
      gap_q         <= gap_d;
      frames_sent   <= sent_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tlast  <= tlast_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_packet_gen.sv
// Directed bench for axi_stream_packet_gen: frame patterns, gaps, backpressure, reset.
module tb_axi_stream_packet_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_frames;
  logic [15:0] frame_len;
  logic [7:0]  ifg;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic [15:0] frames_sent;

  int tests  = 0;
  int failed = 0;

  axi_stream_packet_gen #(.LEN_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_frames(num_frames),
    .frame_len(frame_len), .ifg(ifg), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] nf, input logic [15:0] len, input logic [7:0] g);
    num_frames = nf;
    frame_len  = len;
    ifg        = g;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic l);
    check(tag, 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'({1'b1, l, d}));
    step();
  endtask

  task automatic expect_done(input string tag, input logic [15:0] sent);
    check(tag, 32'({busy, done, m_axis_tvalid, frames_sent}), 32'({1'b0, 1'b1, 1'b0, sent}));
    step();
    check({tag, "_pulse_end"}, 32'(done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 32'({m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done, frames_sent}), 32'd0);
  endtask

  initial begin
    logic [7:0]  seq_b [6];
    int          fi, ki, beats, bad_data, bad_stable, cycles;
    logic        prev_stall;
    logic [9:0]  prev_vec;
    logic [7:0]  f3_b0, f3_b252, f3_b253, f3_b299;

    rst_n = 1'b0; start = 1'b0; num_frames = '0; frame_len = '0; ifg = '0;
    m_axis_tready = 1'b1;
    step(); step();
    check_reset_outputs("reset_values");
    rst_n = 1'b1;
    step();
    check(("idle_after_reset"), 32'({busy, m_axis_tvalid}), 32'd0);

    // One 4-byte frame
    start_run(16'd1, 16'd4, 8'd0);
    check("a_busy_first", 32'(busy), 32'd1);
    expect_beat("a_b0", 8'h00, 1'b0);
    expect_beat("a_b1", 8'h01, 1'b0);
    expect_beat("a_b2", 8'h02, 1'b0);
    expect_beat("a_b3", 8'h03, 1'b1);
    expect_done("a_done", 16'd1);

    // Three 2-byte frames back-to-back, accepted right after the previous done
    start_run(16'd3, 16'd2, 8'd0);
    seq_b = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03};
    for (int i = 0; i < 6; i++) expect_beat($sformatf("b_beat%0d", i), seq_b[i], 1'(i % 2));
    expect_done("b_done", 16'd3);

    // Two 3-byte frames with a 5-cycle gap
    start_run(16'd2, 16'd3, 8'd5);
    expect_beat("c_f0b0", 8'h00, 1'b0);
    expect_beat("c_f0b1", 8'h01, 1'b0);
    expect_beat("c_f0b2", 8'h02, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("c_gap%0d", i), 32'({m_axis_tvalid, busy}), 32'b01);
      step();
    end
    expect_beat("c_f1b0", 8'h01, 1'b0);
    expect_beat("c_f1b1", 8'h02, 1'b0);
    expect_beat("c_f1b2", 8'h03, 1'b1);
    expect_done("c_done", 16'd2);

    // Random backpressure, four 300-byte frames
    start_run(16'd4, 16'd300, 8'd0);
    fi = 0; ki = 0; beats = 0; bad_data = 0; bad_stable = 0; cycles = 0;
    prev_stall = 1'b0; prev_vec = '0;
    f3_b0 = '1; f3_b252 = '0; f3_b253 = '1; f3_b299 = '0;
    while (!done && cycles < 6000) begin
      if (prev_stall && ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== prev_vec))
        bad_stable++;
      m_axis_tready = 1'($urandom_range(0, 1));
      if (m_axis_tvalid && m_axis_tready) begin
        if (m_axis_tdata !== 8'(fi + ki) || m_axis_tlast !== (ki == 299)) bad_data++;
        if (fi == 3 && ki == 0)   f3_b0   = m_axis_tdata;
        if (fi == 3 && ki == 252) f3_b252 = m_axis_tdata;
        if (fi == 3 && ki == 253) f3_b253 = m_axis_tdata;
        if (fi == 3 && ki == 299) f3_b299 = m_axis_tdata;
        beats++;
        if (ki == 299) begin ki = 0; fi++; end
        else ki++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_vec   = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
      step();
      cycles++;
    end
    check("d_done_seen", 32'(done), 32'd1);
    check("d_data_errors", 32'(bad_data), 32'd0);
    check("d_stall_errors", 32'(bad_stable), 32'd0);
    check("d_beats", 32'(beats), 32'd1200);
    check("d_frames_model", 32'(fi), 32'd4);
    check("d_frames_sent", 32'(frames_sent), 32'd4);
    check("d_f3_b0", 32'(f3_b0), 32'h03);
    check("d_f3_b252", 32'(f3_b252), 32'hFF);
    check("d_f3_b253", 32'(f3_b253), 32'h00);
    check("d_f3_b299", 32'(f3_b299), 32'h2E);
    m_axis_tready = 1'b1;
    step();

    // frame_len 0 behaves as a 1-byte frame
    start_run(16'd1, 16'd0, 8'd0);
    expect_beat("e_len0", 8'h00, 1'b1);
    expect_done("e_done", 16'd1);

    // Zero-frame run: busy then done, no beats
    start_run(16'd0, 16'd4, 8'd0);
    check("z_n1", 32'({busy, done, m_axis_tvalid}), 32'b100);
    step();
    check("z_n2", 32'({busy, done, m_axis_tvalid, frames_sent}), 32'({3'b010, 16'd0}));
    step();
    check("z_n3", 32'({busy, done, m_axis_tvalid}), 32'b000);

    // start while busy is ignored
    start_run(16'd1, 16'd3, 8'd0);
    num_frames = 16'd5; frame_len = 16'd1; start = 1'b1;
    expect_beat("s_b0", 8'h00, 1'b0);
    expect_beat("s_b1", 8'h01, 1'b0);
    start = 1'b0;
    expect_beat("s_b2", 8'h02, 1'b1);
    expect_done("s_done", 16'd1);

    // Asynchronous reset mid-frame
    start_run(16'd2, 16'd10, 8'd0);
    expect_beat("r_b0", 8'h00, 1'b0);
    expect_beat("r_b1", 8'h01, 1'b0);
    expect_beat("r_b2", 8'h02, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("r_async_reset");
    step();
    rst_n = 1'b1;
    step(); step(); step();
    check("r_idle_hold", 32'({busy, done, m_axis_tvalid, frames_sent}), 32'd0);
    start_run(16'd1, 16'd2, 8'd0);
    expect_beat("r_restart_b0", 8'h00, 1'b0);
    expect_beat("r_restart_b1", 8'h01, 1'b1);
    expect_done("r_done", 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
